nes_flash_arb: RTL and testbench

- Arbitrates the single external parallel flash between two read requesters:
  - CPU PRG path: mapper/MMC flash address and read data.
  - PPU CHR path: pattern-table fetches.
- Sequences each flash read (chip enable, output enable, wait states, data capture) and returns the byte with a one-cycle acknowledge.
- Sits between the mapper set / PPU fetch logic and the flash pins, replacing the current direct combinational flash hookup.

---
 rtl/nes_flash_pkg.sv | 16 +
 rtl/nes_rr_arb2.sv | 32 +++
 rtl/nes_flash_arb.sv | 145 ++++++++++++++
 tb/tb_nes_flash_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_flash_pkg.sv
// Shared types and constants for the NES flash read arbiter.
package nes_flash_pkg;

    localparam int FL_AW    = 23;
    localparam int FL_DW    = 8;
    localparam int PORT_CPU = 0;
    localparam int PORT_PPU = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        RECOV  = 2'd3
    } fl_state_e;

endpackage

// File: rtl/nes_rr_arb2.sv
// Two-input round-robin arbiter; bit index of req/grant is the port index.
module nes_rr_arb2
    import nes_flash_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic       prio_q;   // 1: PPU wins a tie, 0: CPU wins a tie
    logic [1:0] gnt;

    always_comb begin
        gnt = i_req;
        if (i_req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prio_q <= 1'b1;
        end else if (i_adv) begin
            prio_q <= gnt[PORT_CPU];
        end
    end

    assign o_gnt = gnt;

endmodule

// File: rtl/nes_flash_arb.sv
// Sequences single-byte flash reads for the CPU PRG and PPU CHR paths.
//   state  | meaning
//   IDLE   | no access; grant the next requester
//   ACCESS | CE_n/OE_n low, counting wait states
//   DONE   | data captured, ack pulsing, CE_n/OE_n high
//   RECOV  | recovery gap before the next access
module nes_flash_arb
    import nes_flash_pkg::*;
#(
    parameter int FL_WAIT  = 4,
    parameter int FL_RECOV = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cpu_req,
    input  logic [FL_AW-1:0] i_cpu_addr,
    output logic             o_cpu_ack,
    output logic [FL_DW-1:0] o_cpu_rdata,
    input  logic             i_ppu_req,
    input  logic [FL_AW-1:0] i_ppu_addr,
    output logic             o_ppu_ack,
    output logic [FL_DW-1:0] o_ppu_rdata,
    output logic [FL_AW-1:0] o_fl_addr,
    output logic             o_fl_ce_n,
    output logic             o_fl_oe_n,
    input  logic [FL_DW-1:0] i_fl_rdata,
    output logic             o_busy
);

    localparam logic [3:0] WAIT_LD  = 4'(FL_WAIT - 1);
    localparam logic [3:0] RECOV_LD = (FL_RECOV > 0) ? 4'(FL_RECOV - 1) : 4'd0;

    fl_state_e        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             port_q, port_d;
    logic [FL_AW-1:0] addr_q, addr_d;
    logic             en_n_q, en_n_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             ppu_ack_q, ppu_ack_d;
    logic [FL_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [FL_DW-1:0] ppu_rdata_q, ppu_rdata_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       adv;

    assign req = {i_ppu_req, i_cpu_req};
    assign adv = (state_q == IDLE) && (|req);

    nes_rr_arb2 u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (req),
        .i_adv (adv),
        .o_gnt (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        addr_d      = addr_q;
        en_n_d      = en_n_q;
        cpu_ack_d   = 1'b0;
        ppu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ppu_rdata_d = ppu_rdata_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    port_d  = gnt[PORT_PPU];
                    addr_d  = gnt[PORT_CPU] ? i_cpu_addr : i_ppu_addr;
                    en_n_d  = 1'b0;
                    cnt_d   = WAIT_LD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    en_n_d = 1'b1;
                    if (port_q) begin
                        ppu_ack_d   = 1'b1;
                        ppu_rdata_d = i_fl_rdata;
                    end else begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = i_fl_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (FL_RECOV > 0) begin
                    cnt_d   = RECOV_LD;
                    state_d = RECOV;
                end else begin
                    state_d = IDLE;
                end
            end
            RECOV: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            port_q      <= 1'b0;
            addr_q      <= '0;
            en_n_q      <= 1'b1;
            cpu_ack_q   <= 1'b0;
            ppu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ppu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            en_n_q      <= en_n_d;
            cpu_ack_q   <= cpu_ack_d;
            ppu_ack_q   <= ppu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ppu_rdata_q <= ppu_rdata_d;
        end
    end

    assign o_fl_addr   = addr_q;
    assign o_fl_ce_n   = en_n_q;
    assign o_fl_oe_n   = en_n_q;
    assign o_cpu_ack   = cpu_ack_q;
    assign o_ppu_ack   = ppu_ack_q;
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_ppu_rdata = ppu_rdata_q;
    assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nes_flash_arb.sv
// Scoreboard bench for nes_flash_arb: default timing instance plus a FL_WAIT=1/FL_RECOV=0 instance.
module tb_nes_flash_arb;

    localparam int WA = 4;
    localparam int RA = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        cpu_req = 1'b0, ppu_req = 1'b0;
    logic [22:0] cpu_addr = '0, ppu_addr = '0;
    logic        cpu_ack, ppu_ack, fl_ce_n, fl_oe_n, busy;
    logic [7:0]  cpu_rdata, ppu_rdata, fl_rdata;
    logic [22:0] fl_addr;

    logic        b_req = 1'b0;
    logic [22:0] b_addr = '0;
    logic        b_ack, b_ppu_ack, b_ce_n, b_oe_n, b_busy;
    logic [7:0]  b_rdata, b_ppu_rdata, b_fl_rdata;
    logic [22:0] b_fl_addr;

    logic [7:0]  exp_cpu[$];
    logic [7:0]  exp_ppu[$];
    logic [7:0]  exp_b[$];
    bit          exp_order[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fdat(input logic [22:0] a);
        if (a == 23'h012345) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Flash drives valid data only while selected; 0xFF otherwise.
    assign fl_rdata   = (!fl_ce_n && !fl_oe_n) ? fdat(fl_addr) : 8'hFF;
    assign b_fl_rdata = (!b_ce_n && !b_oe_n) ? fdat(b_fl_addr) : 8'hFF;

    nes_flash_arb #(.FL_WAIT(WA), .FL_RECOV(RA)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
        .i_ppu_req(ppu_req), .i_ppu_addr(ppu_addr), .o_ppu_ack(ppu_ack), .o_ppu_rdata(ppu_rdata),
        .o_fl_addr(fl_addr), .o_fl_ce_n(fl_ce_n), .o_fl_oe_n(fl_oe_n), .i_fl_rdata(fl_rdata),
        .o_busy(busy)
    );

    nes_flash_arb #(.FL_WAIT(1), .FL_RECOV(0)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(b_req), .i_cpu_addr(b_addr), .o_cpu_ack(b_ack), .o_cpu_rdata(b_rdata),
        .i_ppu_req(1'b0), .i_ppu_addr(23'h0), .o_ppu_ack(b_ppu_ack), .o_ppu_rdata(b_ppu_rdata),
        .o_fl_addr(b_fl_addr), .o_fl_ce_n(b_ce_n), .o_fl_oe_n(b_oe_n), .i_fl_rdata(b_fl_rdata),
        .o_busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor for the default instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_ack || ppu_ack) chk("ack_overlap", {31'd0, cpu_ack && ppu_ack}, 32'd0);
            if (cpu_ack) begin
                if (exp_cpu.size() == 0 || exp_order.size() == 0) chk("cpu_unexpected_ack", 32'd1, 32'd0);
                else begin
                    chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_cpu.pop_front()});
                    chk("cpu_order", {31'd0, exp_order.pop_front()}, 32'd0);
                end
            end
            if (ppu_ack) begin
                if (exp_ppu.size() == 0 || exp_order.size() == 0) chk("ppu_unexpected_ack", 32'd1, 32'd0);
                else begin
                    chk("ppu_rdata", {24'd0, ppu_rdata}, {24'd0, exp_ppu.pop_front()});
                    chk("ppu_order", {31'd0, exp_order.pop_front()}, 32'd1);
                end
            end
        end
    end

    // Flash pin monitor: CE low run length, address stability, recovery gap.
    int          low_run = 0, high_run = 0, acc_cnt = 0;
    bit          seen_low = 0;
    logic [22:0] addr_hold = '0;
    always @(negedge clk) begin
        if (rst) begin
            low_run = 0; high_run = 0; seen_low = 0;
        end else if (!fl_ce_n) begin
            chk("oe_follows_ce", {31'd0, fl_oe_n}, 32'd0);
            if (low_run == 0) begin
                acc_cnt++;
                addr_hold = fl_addr;
                if (seen_low) chk("recov_gap_ok", {31'd0, high_run >= 1 + RA}, 32'd1);
            end else begin
                chk("addr_stable", {9'd0, fl_addr}, {9'd0, addr_hold});
            end
            low_run++; high_run = 0; seen_low = 1;
        end else begin
            if (low_run != 0) chk("ce_low_cycles", low_run, WA);
            low_run = 0;
            high_run++;
        end
    end

    // Monitor for the FL_WAIT=1 instance: data and ack spacing.
    int b_last = -1;
    always @(negedge clk) begin
        if (!rst && b_ack) begin
            if (exp_b.size() == 0) chk("b_unexpected_ack", 32'd1, 32'd0);
            else chk("b_rdata", {24'd0, b_rdata}, {24'd0, exp_b.pop_front()});
            if (b_last >= 0) chk("b_ack_spacing", cyc - b_last, 3);
            b_last = cyc;
        end
    end

    task automatic do_read(input bit is_ppu, input logic [22:0] addr, output int lat);
        bit got = 0;
        lat = 0;
        if (is_ppu) begin ppu_req = 1'b1; ppu_addr = addr; exp_ppu.push_back(fdat(addr)); end
        else        begin cpu_req = 1'b1; cpu_addr = addr; exp_cpu.push_back(fdat(addr)); end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (is_ppu ? ppu_ack : cpu_ack) got = 1;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        if (is_ppu) ppu_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic b_read(input logic [22:0] addr);
        bit got = 0;
        b_req = 1'b1; b_addr = addr; exp_b.push_back(fdat(addr));
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_ack) got = 1;
        end
        if (!got) chk("b_ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int  lat1, lat2, acc0;
        bit  got;
        repeat (2) @(negedge clk);
        chk("rst_ce_n",  {31'd0, fl_ce_n}, 32'd1);
        chk("rst_oe_n",  {31'd0, fl_oe_n}, 32'd1);
        chk("rst_addr",  {9'd0, fl_addr}, 32'd0);
        chk("rst_acks",  {30'd0, cpu_ack, ppu_ack}, 32'd0);
        chk("rst_rdata", {16'd0, cpu_rdata, ppu_rdata}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single CPU read at 0x012345.
        exp_order.push_back(1'b0);
        fork
            do_read(1'b0, 23'h012345, lat1);
            begin
                @(negedge clk);
                chk("single_addr", {9'd0, fl_addr}, 32'h012345);
                chk("single_ce",   {31'd0, fl_ce_n}, 32'd0);
                chk("single_busy", {31'd0, busy}, 32'd1);
            end
        join
        chk("single_latency", lat1, WA + 1);
        repeat (4) @(negedge clk);
        chk("single_rdata_hold", {24'd0, cpu_rdata}, 32'h0000_00A5);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // Simultaneous requests: PPU first, then strict alternation.
        for (int i = 0; i < 16; i++) exp_order.push_back(i[0] ? 1'b0 : 1'b1);
        fork
            begin for (int i = 0; i < 8; i++) do_read(1'b0, 23'h000010 + 23'(i), lat1); end
            begin for (int i = 0; i < 8; i++) do_read(1'b1, 23'h400020 + 23'(i), lat2); end
        join
        repeat (6) @(negedge clk);

        // Address change mid-access is ignored; data for 0x000100 is 0x3D.
        exp_order.push_back(1'b0);
        fork
            do_read(1'b0, 23'h000100, lat1);
            begin
                repeat (3) @(negedge clk);
                cpu_addr = 23'h000200;
                @(negedge clk);
                chk("addr_change_flash_addr", {9'd0, fl_addr}, 32'h000100);
            end
        join
        chk("addr_change_rdata", {24'd0, cpu_rdata}, 32'h3D);
        repeat (6) @(negedge clk);

        // PPU drops req two cycles into its access.
        acc0 = acc_cnt;
        ppu_req = 1'b1; ppu_addr = 23'h400010;
        exp_ppu.push_back(8'h2C); exp_order.push_back(1'b1);
        got = 0; lat1 = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat1++;
            if (lat1 == 3) ppu_req = 1'b0;
            if (ppu_ack) got = 1;
        end
        ppu_req = 1'b0;
        chk("drop_latency", lat1, WA + 1);
        repeat (12) @(negedge clk);
        chk("drop_single_access", acc_cnt, acc0 + 1);
        chk("drop_rdata_hold", {24'd0, ppu_rdata}, 32'h2C);

        // Reset during ACCESS acts without a clock edge.
        cpu_req = 1'b1; cpu_addr = 23'h000155;
        repeat (3) @(negedge clk);
        chk("pre_rst_ce_low", {31'd0, fl_ce_n}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ce_n", {31'd0, fl_ce_n}, 32'd1);
        chk("async_rst_oe_n", {31'd0, fl_oe_n}, 32'd1);
        chk("async_rst_acks", {30'd0, cpu_ack, ppu_ack}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_rdata", {24'd0, cpu_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_cpu.push_back(8'h68); exp_order.push_back(1'b0);
        got = 0; lat1 = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat1++;
            if (cpu_ack) got = 1;
        end
        cpu_req = 1'b0;
        chk("post_rst_latency", lat1, WA + 1);

        // FL_WAIT=1, FL_RECOV=0: continuous CPU requests.
        for (int i = 0; i < 6; i++) b_read(23'h000111 * 23'(i + 1));
        b_req = 1'b0;

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_cpu.size() + exp_ppu.size() + exp_order.size() + exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
